// File: rtl/sdr_app_arb.sv
// Two-port arbiter in front of an SDRAM controller application interface.
// One transaction is in flight at a time. Arbitration is either fixed-priority (port 0) or round-robin.
module sdr_app_arb #(
   parameter int APP_AW = 26,
   parameter int APP_DW = 32,
   parameter int APP_BW = 4,
   parameter int APP_RW = 9
) (
   input  logic                  sdram_clk,
   input  logic                  reset_n,
   input  logic                  cfg_fixed_pri,
   input  logic [1:0]            m_req,
   input  logic [2*APP_AW-1:0]   m_addr,
   input  logic [2*APP_RW-1:0]   m_len,
   input  logic [1:0]            m_wr_n,
   input  logic [1:0]            m_wrap,
   input  logic [2*APP_DW-1:0]   m_wr_data,
   input  logic [2*APP_BW-1:0]   m_wr_en_n,
   output logic [1:0]            m_ack,
   output logic [1:0]            m_wr_next,
   output logic [1:0]            m_rd_valid,
   output logic [1:0]            m_last,
   output logic [APP_DW-1:0]     m_rd_data,
   output logic                  app_req,
   output logic [APP_AW-1:0]     app_req_addr,
   output logic [APP_RW-1:0]     app_req_len,
   output logic                  app_req_wr_n,
   output logic                  app_req_wrap,
   output logic [APP_DW-1:0]     app_wr_data,
   output logic [APP_BW-1:0]     app_wr_en_n,
   input  logic                  app_req_ack,
   input  logic                  app_wr_next_req,
   input  logic                  app_rd_valid,
   input  logic                  app_last_rd,
   input  logic                  app_last_wr,
   input  logic [APP_DW-1:0]     app_rd_data
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WR   = 2'd2,
      ST_RD   = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic                gnt_r;
   logic                last_gnt_r;
   logic                win_s;
   logic [APP_AW-1:0]   addr_r;
   logic [APP_RW-1:0]   len_r;
   logic                wr_n_r;
   logic                wrap_r;

   // Winner selection: a lone requester always wins; a tie is settled by priority mode.
   always_comb begin
      win_s = 1'b0;
      if (m_req == 2'b11) begin
         if (cfg_fixed_pri) begin
            win_s = 1'b0;
         end else begin
            win_s = ~last_gnt_r;
         end
      end else if (m_req[1]) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // State register, grant and latched request fields.
   always_ff @(posedge sdram_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         gnt_r      <= 1'b0;
         last_gnt_r <= 1'b1;
         addr_r     <= {APP_AW{1'b0}};
         len_r      <= {APP_RW{1'b0}};
         wr_n_r     <= 1'b0;
         wrap_r     <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_IDLE) && (m_req != 2'b00)) begin
            gnt_r  <= win_s;
            addr_r <= win_s ? m_addr[2*APP_AW-1:APP_AW] : m_addr[APP_AW-1:0];
            len_r  <= win_s ? m_len[2*APP_RW-1:APP_RW]  : m_len[APP_RW-1:0];
            wr_n_r <= win_s ? m_wr_n[1] : m_wr_n[0];
            wrap_r <= win_s ? m_wrap[1] : m_wrap[0];
         end
         if (((state_r == ST_WR) && app_last_wr) || ((state_r == ST_RD) && app_last_rd)) begin
            last_gnt_r <= gnt_r;
         end
      end
   end

   // Next-state logic; a write whose last beat coincides with ack skips the WR state.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (m_req != 2'b00) state_nxt_s = ST_REQ;
            else                state_nxt_s = ST_IDLE;
         end
         ST_REQ: begin
            if (!app_req_ack)     state_nxt_s = ST_REQ;
            else if (wr_n_r)      state_nxt_s = ST_RD;
            else if (app_last_wr) state_nxt_s = ST_IDLE;
            else                  state_nxt_s = ST_WR;
         end
         ST_WR: begin
            if (app_last_wr) state_nxt_s = ST_IDLE;
            else             state_nxt_s = ST_WR;
         end
         ST_RD: begin
            if (app_last_rd) state_nxt_s = ST_IDLE;
            else             state_nxt_s = ST_RD;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   assign app_req      = (state_r == ST_REQ);
   assign app_req_addr = addr_r;
   assign app_req_len  = len_r;
   assign app_req_wr_n = wr_n_r;
   assign app_req_wrap = wrap_r;

   // Response routing to the granted port only; idle values elsewhere.
   always_comb begin
      m_ack       = 2'b00;
      m_wr_next   = 2'b00;
      m_rd_valid  = 2'b00;
      m_last      = 2'b00;
      m_rd_data   = {APP_DW{1'b0}};
      app_wr_data = {APP_DW{1'b0}};
      app_wr_en_n = {APP_BW{1'b1}};
      case (state_r)
         ST_REQ: begin
            m_ack[gnt_r]  = app_req_ack;
            m_last[gnt_r] = app_req_ack & ~wr_n_r & app_last_wr;
         end
         ST_WR: begin
            app_wr_data      = gnt_r ? m_wr_data[2*APP_DW-1:APP_DW] : m_wr_data[APP_DW-1:0];
            app_wr_en_n      = gnt_r ? m_wr_en_n[2*APP_BW-1:APP_BW] : m_wr_en_n[APP_BW-1:0];
            m_wr_next[gnt_r] = app_wr_next_req;
            m_last[gnt_r]    = app_last_wr;
         end
         ST_RD: begin
            m_rd_valid[gnt_r] = app_rd_valid;
            m_last[gnt_r]     = app_last_rd;
            m_rd_data         = app_rd_data;
         end
         default: begin
            m_ack = 2'b00;
         end
      endcase
   end

endmodule

// File: doc/sdr_app_arb.md
SDR_APP_ARB -- requirements
Module: sdr_app_arb

Interface
REQ-001 SHALL have parameter APP_AW, default 26, application address width.
REQ-002 SHALL have parameter APP_DW, default 32, application data width.
REQ-003 SHALL have parameter APP_BW, default 4, byte-enable width (APP_DW/8).
REQ-004 SHALL have parameter APP_RW, default 9, request length width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports are listed in REQ-006 and REQ-007.
REQ-006 SHALL have port sdram_clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port cfg_fixed_pri  in  1  1 = port 0 always wins; 0 = round-robin.
REQ-009 SHALL have port m_req  in  2  per-requester request, bit i = port i.
REQ-010 SHALL have port m_addr  in  2*APP_AW  per-port address, port i at slice i.
REQ-011 SHALL have port m_len  in  2*APP_RW  per-port burst length in words.
REQ-012 SHALL have port m_wr_n  in  2  per-port direction, 0 = write, 1 = read.
REQ-013 SHALL have port m_wrap  in  2  per-port address wrap.
REQ-014 SHALL have port m_wr_data  in  2*APP_DW  per-port write data.
REQ-015 SHALL have port m_wr_en_n  in  2*APP_BW  per-port byte write enable, active low.
REQ-016 SHALL have port m_ack  out  2  per-port request accepted.
REQ-017 SHALL have port m_wr_next  out  2  per-port next-write-data strobe.
REQ-018 SHALL have port m_rd_valid  out  2  per-port read data valid.
REQ-019 SHALL have port m_last  out  2  per-port last beat, read or write.
REQ-020 SHALL have port m_rd_data  out  APP_DW  read data, broadcast to both ports.
REQ-021 SHALL have ports app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_wrap, app_wr_data and app_wr_en_n  out  1/APP_AW/APP_RW/1/1/APP_DW/APP_BW  controller request side.
REQ-022 SHALL have ports app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd and app_last_wr  in  1 each, and app_rd_data  in  APP_DW  controller response side.

Function
REQ-023 SHALL implement the FSM IDLE -> REQ -> (WR | RD) -> IDLE, with one transaction outstanding at a time.
REQ-024 IDLE: if m_req != 0 at an edge, SHALL register gnt and latch the granted port's addr, len, wr_n and wrap, then go to REQ; app_req SHALL be high in the next cycle.
REQ-025 Arbitration: if cfg_fixed_pri = 1, port 0 SHALL win; otherwise the port not equal to last_gnt SHALL win when both request, and a lone requester SHALL always win.
REQ-026 REQ: app_req SHALL be 1 and app_req_* SHALL be driven from the latched registers; m_req SHALL be ignored.
REQ-027 REQ with app_req_ack = 1: m_ack[gnt] SHALL pulse combinationally in the same cycle; the next state SHALL be WR if the latched wr_n = 0, else RD.
REQ-028 If app_last_wr = 1 in the ack cycle, the next state SHALL be IDLE directly (single-beat write).
REQ-029 WR: app_wr_data and app_wr_en_n SHALL be muxed combinationally from port gnt; m_wr_next[gnt] SHALL equal app_wr_next_req; m_last[gnt] SHALL equal app_last_wr; app_last_wr SHALL cause IDLE next.
REQ-030 RD: m_rd_valid[gnt] SHALL equal app_rd_valid; m_last[gnt] SHALL equal app_last_rd; m_rd_data SHALL equal app_rd_data; app_last_rd SHALL cause IDLE next.
REQ-031 On leaving WR or RD, last_gnt SHALL be updated to gnt.
REQ-032 Outside WR, app_wr_en_n SHALL be all ones and app_wr_data zero; outside REQ, app_req SHALL be 0.
REQ-033 Non-granted port bits of m_ack, m_wr_next, m_rd_valid and m_last SHALL always be 0.
REQ-034 A requester MAY drop m_req after its ack; a requester dropping m_req before its ack SHALL not affect the request already latched.
REQ-035 Back-to-back operation: the minimum gap between the last beat and the next app_req rise SHALL be 1 cycle (the IDLE cycle).

Reset
REQ-036 When reset_n = 0 (asynchronous), the FSM SHALL go to IDLE, gnt SHALL be 0, last_gnt SHALL be 1, latched fields SHALL be 0, and all outputs SHALL be 0 except app_wr_en_n, which SHALL be all ones.
REQ-037 Reset asserted mid-transaction SHALL abort with no further m_* strobes; after release, arbitration SHALL restart from IDLE.

Verification
REQ-038 Reset, then m_req = 01 with a write of len 4 and addr 0x100: app_req rises 1 cycle later with addr 0x100; on ack, m_ack = 01; 4 wr_next beats route to port 0; IDLE after app_last_wr.
REQ-039 m_req = 11 held with cfg_fixed_pri = 0: grants alternate port 0, port 1, port 0, and so on.
REQ-040 m_req = 11 held with cfg_fixed_pri = 1: port 0 is granted on every transaction.
REQ-041 Port 1 read of len 8: exactly 8 m_rd_valid[1] pulses, m_last[1] on the 8th, and m_rd_valid[0] stays 0.
REQ-042 Single-beat write with app_last_wr coincident with ack: IDLE next cycle, and m_last[gnt] pulses in the ack cycle.
REQ-043 reset_n dropped during the WR state: all outputs return to reset values immediately, and after release the next grant goes to port 0.
